writeback_stage: RTL and testbench

Final stage of the MIPS pipeline. It captures the memory-stage result into a MEM/WB pipeline register and selects the destination register (rt or rd) and the write value (ALU result or load data). It drives the register-file write port consumed by `decode_stage` (`write_data`, `write_register_index`, `RegWrite`). It also holds a one-entry bypass record of the last committed write and counts retired instructions.

---
 rtl/writeback_stage.sv | 122 ++++++++++++
 tb/tb_writeback_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : MEM/WB pipeline register and register-file write port. Holds a
//            one-entry record of the last committed write for decode bypass
//            and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        RegWrite_in,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic [31:0] alu_result,
  input  logic [31:0] memory_read_data,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic [4:0]  write_register_index,
  output logic        RegWrite,
  output logic        bypass_valid,
  output logic [4:0]  bypass_index,
  output logic [31:0] bypass_data,
  output logic [31:0] retired_count
);

  localparam logic [4:0] c_reg_zero = 5'd0;

  logic [4:0]  w_dest;
  logic [31:0] w_val;

  logic [31:0] write_data_q,           write_data_d;
  logic [4:0]  write_register_index_q, write_register_index_d;
  logic        reg_write_q,            reg_write_d;
  logic        bypass_valid_q,         bypass_valid_d;
  logic [4:0]  bypass_index_q,         bypass_index_d;
  logic [31:0] bypass_data_q,          bypass_data_d;
  logic [31:0] retired_count_q,        retired_count_d;

  // Destination index and write value ahead of the MEM/WB register.
  always_comb begin
    w_dest = RegDst ? rd : rt;
    w_val  = MemtoReg ? memory_read_data : alu_result;
  end

  // MEM/WB capture: flush beats stall; a bubble clears like a flush.
  always_comb begin
    write_data_d           = write_data_q;
    write_register_index_d = write_register_index_q;
    reg_write_d            = reg_write_q;
    if (flush) begin
      write_data_d           = 32'd0;
      write_register_index_d = 5'd0;
      reg_write_d            = 1'b0;
    end else if (stall) begin
      // Hold; a held write simply repeats into the register file.
    end else if (!mem_valid) begin
      write_data_d           = 32'd0;
      write_register_index_d = 5'd0;
      reg_write_d            = 1'b0;
    end else begin
      write_data_d           = w_val;
      write_register_index_d = w_dest;
      // Writes to $zero are suppressed but index/data are still latched.
      reg_write_d            = RegWrite_in && (w_dest != c_reg_zero);
    end
  end

  // Bypass record tracks the write the register file commits at this edge.
  always_comb begin
    bypass_valid_d = reg_write_q;
    bypass_index_d = bypass_index_q;
    bypass_data_d  = bypass_data_q;
    if (reg_write_q) begin
      bypass_index_d = write_register_index_q;
      bypass_data_d  = write_data_q;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_comb begin
    retired_count_d = retired_count_q;
    if (mem_valid && !stall && !flush) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_data_q           <= 32'd0;
      write_register_index_q <= 5'd0;
      reg_write_q            <= 1'b0;
      bypass_valid_q         <= 1'b0;
      bypass_index_q         <= 5'd0;
      bypass_data_q          <= 32'd0;
      retired_count_q        <= 32'd0;
    end else begin
      write_data_q           <= write_data_d;
      write_register_index_q <= write_register_index_d;
      reg_write_q            <= reg_write_d;
      bypass_valid_q         <= bypass_valid_d;
      bypass_index_q         <= bypass_index_d;
      bypass_data_q          <= bypass_data_d;
      retired_count_q        <= retired_count_d;
    end
  end

  assign write_data           = write_data_q;
  assign write_register_index = write_register_index_q;
  assign RegWrite             = reg_write_q;
  assign bypass_valid         = bypass_valid_q;
  assign bypass_index         = bypass_index_q;
  assign bypass_data          = bypass_data_q;
  assign retired_count        = retired_count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Directed self-checking bench for writeback_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, stall, flush, RegWrite_in, MemtoReg, RegDst;
  logic [31:0] alu_result, memory_read_data;
  logic [4:0]  rt, rd;
  logic [31:0] write_data;
  logic [4:0]  write_register_index;
  logic        RegWrite;
  logic        bypass_valid;
  logic [4:0]  bypass_index;
  logic [31:0] bypass_data;
  logic [31:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;

  writeback_stage dut (
    .clock                (clock),
    .reset                (reset),
    .mem_valid            (mem_valid),
    .stall                (stall),
    .flush                (flush),
    .RegWrite_in          (RegWrite_in),
    .MemtoReg             (MemtoReg),
    .RegDst               (RegDst),
    .alu_result           (alu_result),
    .memory_read_data     (memory_read_data),
    .rt                   (rt),
    .rd                   (rd),
    .write_data           (write_data),
    .write_register_index (write_register_index),
    .RegWrite             (RegWrite),
    .bypass_valid         (bypass_valid),
    .bypass_index         (bypass_index),
    .bypass_data          (bypass_data),
    .retired_count        (retired_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every output against the expected tuple.
  task automatic chk_all(input string tag,
                         input logic [31:0] wd, input logic [4:0] wi, input logic rw,
                         input logic bv, input logic [4:0] bi, input logic [31:0] bd,
                         input logic [31:0] rc);
    chk({tag, ".write_data"},   write_data,                  wd);
    chk({tag, ".wr_index"},     {27'd0, write_register_index}, {27'd0, wi});
    chk({tag, ".RegWrite"},     {31'd0, RegWrite},           {31'd0, rw});
    chk({tag, ".bypass_valid"}, {31'd0, bypass_valid},       {31'd0, bv});
    chk({tag, ".bypass_index"}, {27'd0, bypass_index},       {27'd0, bi});
    chk({tag, ".bypass_data"},  bypass_data,                 bd);
    chk({tag, ".retired"},      retired_count,               rc);
  endtask

  // Apply inputs at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic s, input logic f, input logic rwi,
                      input logic m2r, input logic rdst, input logic [31:0] alu,
                      input logic [31:0] mrd, input logic [4:0] t, input logic [4:0] d);
    @(negedge clock);
    mem_valid = v; stall = s; flush = f; RegWrite_in = rwi; MemtoReg = m2r;
    RegDst = rdst; alu_result = alu; memory_read_data = mrd; rt = t; rd = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 0; stall = 0; flush = 0; RegWrite_in = 0; MemtoReg = 0; RegDst = 0;
    alu_result = 0; memory_read_data = 0; rt = 0; rd = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset_init", 32'd0, 5'd0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // R-type to rd=5, then a bubble so the bypass record can be seen.
    step(1, 0, 0, 1, 0, 1, 32'h0000_00FF, 32'h0, 5'd9, 5'd5);
    chk_all("rtype_e1", 32'hFF, 5'd5, 1, 0, 5'd0, 32'd0, 32'd1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
    chk_all("rtype_e2", 32'd0, 5'd0, 0, 1, 5'd5, 32'hFF, 32'd1);

    // Load into rt=3.
    step(1, 0, 0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF, 5'd3, 5'd12);
    chk_all("load", 32'hDEAD_BEEF, 5'd3, 1, 0, 5'd5, 32'hFF, 32'd2);

    // Write to $zero: suppressed, still retired; bypass records the load.
    step(1, 0, 0, 1, 0, 1, 32'h55, 32'h0, 5'd4, 5'd0);
    chk_all("zero_reg", 32'h55, 5'd0, 0, 1, 5'd3, 32'hDEAD_BEEF, 32'd3);

    // Bubble: write port cleared, count held, bypass invalid but holds.
    step(0, 0, 0, 1, 0, 1, 32'h77, 32'h0, 5'd8, 5'd8);
    chk_all("bubble", 32'd0, 5'd0, 0, 0, 5'd3, 32'hDEAD_BEEF, 32'd3);

    // Capture reg7 = 0x1234, then stall 3 cycles with changing inputs.
    step(1, 0, 0, 1, 0, 1, 32'h1234, 32'h0, 5'd2, 5'd7);
    chk_all("cap7", 32'h1234, 5'd7, 1, 0, 5'd3, 32'hDEAD_BEEF, 32'd4);
    step(1, 1, 0, 1, 1, 0, 32'hAAAA, 32'hBBBB, 5'd11, 5'd13);
    chk_all("stall1", 32'h1234, 5'd7, 1, 1, 5'd7, 32'h1234, 32'd4);
    step(1, 1, 0, 1, 0, 1, 32'hCCCC, 32'hDDDD, 5'd14, 5'd15);
    chk_all("stall2", 32'h1234, 5'd7, 1, 1, 5'd7, 32'h1234, 32'd4);
    step(0, 1, 0, 0, 0, 0, 32'hEEEE, 32'hFFFF, 5'd16, 5'd17);
    chk_all("stall3", 32'h1234, 5'd7, 1, 1, 5'd7, 32'h1234, 32'd4);

    // Stall plus flush: flush wins, no retire; bypass drops one edge later.
    step(1, 1, 1, 1, 0, 1, 32'h9999, 32'h0, 5'd1, 5'd9);
    chk_all("stall_flush", 32'd0, 5'd0, 0, 1, 5'd7, 32'h1234, 32'd4);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
    chk_all("post_flush", 32'd0, 5'd0, 0, 0, 5'd7, 32'h1234, 32'd4);

    // Flush alone on a valid instruction: not retired.
    step(1, 0, 1, 1, 0, 1, 32'h4321, 32'h0, 5'd1, 5'd6);
    chk_all("flush_only", 32'd0, 5'd0, 0, 0, 5'd7, 32'h1234, 32'd4);

    // Counter wrap: preload the count to all ones, then retire one.
    @(negedge clock);
    mem_valid = 0; stall = 0; flush = 0;
    force dut.retired_count_d = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    release dut.retired_count_d;
    chk("wrap_preload", retired_count, 32'hFFFF_FFFF);
    step(1, 0, 0, 0, 0, 0, 32'h1, 32'h0, 5'd10, 5'd0);
    chk("wrap", retired_count, 32'h0000_0000);
    chk("wrap_rw", {31'd0, RegWrite}, 32'd0);

    // Asynchronous reset mid-operation with nonzero inputs.
    step(1, 0, 0, 1, 0, 1, 32'h5A5A, 32'h0, 5'd0, 5'd20);
    chk_all("pre_reset", 32'h5A5A, 5'd20, 1, 0, 5'd7, 32'h1234, 32'd1);
    @(negedge clock);
    #2;
    mem_valid = 1; RegWrite_in = 1; RegDst = 1; rd = 5'd21; alu_result = 32'h6B6B;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 32'd0, 5'd0, 0, 0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset_hold", 32'd0, 5'd0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_all("after_reset", 32'h6B6B, 5'd21, 1, 0, 5'd0, 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
